// File: rtl/ct_idu_rf_prf_pkg.sv
// Shared constants and helpers for the IDU RF physical-register bank.
// Optional feature macro used by the bank: CT_IDU_PRF_BYPASS_EN.
package ct_idu_rf_prf_pkg;

  localparam int NUM_PREG_D = 96;
  localparam int DATA_W_D   = 64;
  localparam int NUM_WB_D   = 3;
  localparam int NUM_RD_D   = 4;
  localparam int NUM_ARCH_D = 32;

  // Width of the generic vectors handed to the encode helpers.
  localparam int ENC_W = 256;

  // Architectural pregs come out of reset holding committed (ready) state.
  function automatic logic rst_ready(input int idx, input int num_arch);
    return (idx < num_arch);
  endfunction

  // Keep only the lowest set bit; the lowest port wins a writeback collision.
  function automatic logic [ENC_W-1:0] lowest_onehot(input logic [ENC_W-1:0] vec);
    return vec & (~vec + 1'b1);
  endfunction

  // Index of the lowest set bit, 0 when nothing is set.
  function automatic int lowest_set(input logic [ENC_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = ENC_W - 1; i >= 0; i--)
      if (vec[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/ct_idu_rf_prf_bank_if.sv
// Writeback / allocate / read / conflict bundle of the PRF bank.
// master: rename, writeback pipes and issue read; slave: the bank.
interface ct_idu_rf_prf_bank_if #(
  parameter int NUM_PREG = 96,
  parameter int DATA_W   = 64,
  parameter int NUM_WB   = 3,
  parameter int NUM_RD   = 4
);
  localparam int PREG_W = $clog2(NUM_PREG);

  logic [NUM_WB-1:0]              wb_vld;
  logic [NUM_WB-1:0][PREG_W-1:0]  wb_preg;
  logic [NUM_WB-1:0][DATA_W-1:0]  wb_data;
  logic                           alloc_vld;
  logic [PREG_W-1:0]              alloc_preg;
  logic [NUM_RD-1:0]              rd_vld;
  logic [NUM_RD-1:0][PREG_W-1:0]  rd_preg;
  logic [NUM_RD-1:0]              rd_data_vld;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]              rd_rdy;
  logic                           wb_conflict;
  logic [PREG_W-1:0]              wb_conflict_preg;
  logic                           conflict_clr;

  modport master (
    output wb_vld, wb_preg, wb_data, alloc_vld, alloc_preg, rd_vld, rd_preg, conflict_clr,
    input  rd_data_vld, rd_data, rd_rdy, wb_conflict, wb_conflict_preg
  );

  modport slave (
    input  wb_vld, wb_preg, wb_data, alloc_vld, alloc_preg, rd_vld, rd_preg, conflict_clr,
    output rd_data_vld, rd_data, rd_rdy, wb_conflict, wb_conflict_preg
  );
endinterface

// File: rtl/ct_idu_rf_prf_bank_entry.sv
// One physical register: writeback port select, data/ready state and a
// local collision flag (multiple writers, or writer plus allocate).
module ct_idu_rf_prf_bank_entry
  import ct_idu_rf_prf_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int DATA_W  = 64,
  parameter int NUM_WB  = 3,
  parameter int PREG_W  = 7,
  parameter bit RST_RDY = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WB-1:0]             wb_vld,
  input  logic [NUM_WB-1:0][PREG_W-1:0] wb_preg,
  input  logic [NUM_WB-1:0][DATA_W-1:0] wb_data,
  input  logic                          alloc_vld,
  input  logic [PREG_W-1:0]             alloc_preg,
  output logic [DATA_W-1:0]             data,
  output logic                          ready,
  output logic                          wr_hit,
  output logic [DATA_W-1:0]             wr_data,
  output logic                          alloc_hit,
  output logic                          collide
);
  localparam logic [PREG_W-1:0] IDX_L = PREG_W'(IDX);

  logic [NUM_WB-1:0] hit;
  logic [ENC_W-1:0]  oh;

  // Decode which writeback ports target this entry and pick the lowest one.
  always_comb begin
    for (int p = 0; p < NUM_WB; p++)
      hit[p] = wb_vld[p] && (wb_preg[p] == IDX_L);
    oh      = lowest_onehot(ENC_W'(hit));
    wr_data = '0;
    for (int p = 0; p < NUM_WB; p++)
      wr_data = wr_data | ({DATA_W{oh[p]}} & wb_data[p]);
    wr_hit    = |hit;
    alloc_hit = alloc_vld && (alloc_preg == IDX_L);
    collide   = (|(hit & ~oh[NUM_WB-1:0])) || (wr_hit && alloc_hit);
  end

  // Data and ready state; allocate beats writeback on the ready bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      ready <= RST_RDY;
    end else begin
      if (wr_hit) data <= wr_data;
      if (alloc_hit)   ready <= 1'b0;
      else if (wr_hit) ready <= 1'b1;
    end
  end
endmodule

// File: rtl/ct_idu_rf_prf_bank.sv
// Integer PRF bank: NUM_PREG entries, NUM_WB writeback ports, NUM_RD
// registered read ports, ready scoreboard and sticky collision capture.
// Optional macro CT_IDU_PRF_BYPASS_EN forwards same-cycle writeback to reads.
module ct_idu_rf_prf_bank
  import ct_idu_rf_prf_pkg::*;
#(
  parameter int NUM_PREG = NUM_PREG_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int NUM_WB   = NUM_WB_D,
  parameter int NUM_RD   = NUM_RD_D,
  parameter int NUM_ARCH = NUM_ARCH_D
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  ct_idu_rf_prf_bank_if.slave   bus
);
  localparam int PREG_W = $clog2(NUM_PREG);
  localparam logic [PREG_W:0] NUM_PREG_L = (PREG_W+1)'(NUM_PREG);

  logic [NUM_PREG-1:0][DATA_W-1:0] ent_data;
  logic [NUM_PREG-1:0][DATA_W-1:0] ent_wr_data;
  logic [NUM_PREG-1:0]             ent_rdy;
  logic [NUM_PREG-1:0]             ent_wr_hit;
  logic [NUM_PREG-1:0]             ent_alloc_hit;
  logic [NUM_PREG-1:0]             ent_col;

  logic [NUM_RD-1:0][DATA_W-1:0]   nxt_data;
  logic [NUM_RD-1:0]               nxt_rdy;
  logic                            any_col;
  logic [PREG_W-1:0]               col_idx;

  for (genvar i = 0; i < NUM_PREG; i++) begin : g_ent
    ct_idu_rf_prf_bank_entry #(
      .IDX     (i),
      .DATA_W  (DATA_W),
      .NUM_WB  (NUM_WB),
      .PREG_W  (PREG_W),
      .RST_RDY (rst_ready(i, NUM_ARCH))
    ) u_ent (
      .clk        (forever_cpuclk),
      .rst        (cpurst),
      .wb_vld     (bus.wb_vld),
      .wb_preg    (bus.wb_preg),
      .wb_data    (bus.wb_data),
      .alloc_vld  (bus.alloc_vld),
      .alloc_preg (bus.alloc_preg),
      .data       (ent_data[i]),
      .ready      (ent_rdy[i]),
      .wr_hit     (ent_wr_hit[i]),
      .wr_data    (ent_wr_data[i]),
      .alloc_hit  (ent_alloc_hit[i]),
      .collide    (ent_col[i])
    );
  end

  // Read mux: out-of-range indices return zero / not ready.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      nxt_data[r] = '0;
      nxt_rdy[r]  = 1'b0;
      if ({1'b0, bus.rd_preg[r]} < NUM_PREG_L) begin
        nxt_data[r] = ent_data[bus.rd_preg[r]];
        nxt_rdy[r]  = ent_rdy[bus.rd_preg[r]];
`ifdef CT_IDU_PRF_BYPASS_EN
        if (ent_wr_hit[bus.rd_preg[r]]) begin
          nxt_data[r] = ent_wr_data[bus.rd_preg[r]];
          nxt_rdy[r]  = ~ent_alloc_hit[bus.rd_preg[r]];
        end
`endif
      end
    end
  end

  // Read pipeline stage; idle ports keep their last data.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      bus.rd_data_vld <= '0;
      bus.rd_data     <= '0;
      bus.rd_rdy      <= '0;
    end else begin
      bus.rd_data_vld <= bus.rd_vld;
      for (int r = 0; r < NUM_RD; r++) begin
        if (bus.rd_vld[r]) begin
          bus.rd_data[r] <= nxt_data[r];
          bus.rd_rdy[r]  <= nxt_rdy[r];
        end
      end
    end
  end

  always_comb begin
    any_col = |ent_col;
    col_idx = PREG_W'(lowest_set(ENC_W'(ent_col)));
  end

  // Sticky collision flag; the first index is kept until cleared, and a
  // collision coinciding with a clear re-arms with the new index.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      bus.wb_conflict      <= 1'b0;
      bus.wb_conflict_preg <= '0;
    end else if (any_col) begin
      bus.wb_conflict <= 1'b1;
      if (!bus.wb_conflict || bus.conflict_clr) bus.wb_conflict_preg <= col_idx;
    end else if (bus.conflict_clr) begin
      bus.wb_conflict      <= 1'b0;
      bus.wb_conflict_preg <= '0;
    end
  end

`ifndef SYNTHESIS
  // Catch unknown valids and out-of-range indices while out of reset.
  always @(posedge forever_cpuclk) begin
    if (!cpurst) begin
      assert (!$isunknown(bus.wb_vld));
      assert (!$isunknown(bus.rd_vld));
      for (int p = 0; p < NUM_WB; p++)
        assert (!(bus.wb_vld[p] && ({1'b0, bus.wb_preg[p]} >= NUM_PREG_L)));
      for (int r = 0; r < NUM_RD; r++)
        assert (!(bus.rd_vld[r] && ({1'b0, bus.rd_preg[r]} >= NUM_PREG_L)));
      assert (!(bus.alloc_vld && ({1'b0, bus.alloc_preg} >= NUM_PREG_L)));
    end
  end
`endif
endmodule

// File: tb/tb_ct_idu_rf_prf_bank.sv
// Directed self-checking bench for ct_idu_rf_prf_bank (default parameters).
module tb_ct_idu_rf_prf_bank;
  logic forever_cpuclk = 1'b0;
  logic cpurst;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  ct_idu_rf_prf_bank_if bus ();

  ct_idu_rf_prf_bank dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .bus            (bus)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic idle();
    bus.wb_vld       = '0;
    bus.wb_preg      = '0;
    bus.wb_data      = '0;
    bus.alloc_vld    = 1'b0;
    bus.alloc_preg   = '0;
    bus.rd_vld       = '0;
    bus.rd_preg      = '0;
    bus.conflict_clr = 1'b0;
  endtask

  task automatic test_reset();
    cpurst = 1'b1;
    idle();
    step();
    step();
    cpurst = 1'b0;
    tot_cnt++;
    if (bus.rd_data_vld !== 4'b0 || bus.rd_rdy !== 4'b0 || bus.rd_data !== '0)
      $display("FAIL reset_rd vld=%b rdy=%b want 0/0", bus.rd_data_vld, bus.rd_rdy);
    else pass_cnt++;
    tot_cnt++;
    if (bus.wb_conflict !== 1'b0 || bus.wb_conflict_preg !== 7'd0)
      $display("FAIL reset_conflict got %b/%0d want 0/0", bus.wb_conflict, bus.wb_conflict_preg);
    else pass_cnt++;
    bus.rd_vld = 4'b0011;
    bus.rd_preg[0] = 7'd5;
    bus.rd_preg[1] = 7'd40;
    step();
    idle();
    tot_cnt++;
    if (bus.rd_data[0] !== 64'h0 || bus.rd_data[1] !== 64'h0)
      $display("FAIL reset_data got %h %h want 0 0", bus.rd_data[0], bus.rd_data[1]);
    else pass_cnt++;
    tot_cnt++;
    if (bus.rd_rdy[1:0] !== 2'b01 || bus.rd_data_vld !== 4'b0011)
      $display("FAIL reset_rdy rdy=%b vld=%b want 01/0011", bus.rd_rdy[1:0], bus.rd_data_vld);
    else pass_cnt++;
  endtask

  task automatic test_wb_ports();
    bus.wb_vld = 3'b111;
    bus.wb_preg[0] = 7'd33; bus.wb_data[0] = 64'h11;
    bus.wb_preg[1] = 7'd34; bus.wb_data[1] = 64'h22;
    bus.wb_preg[2] = 7'd35; bus.wb_data[2] = 64'h33;
    step();
    idle();
    bus.rd_vld = 4'b0111;
    bus.rd_preg[0] = 7'd33;
    bus.rd_preg[1] = 7'd34;
    bus.rd_preg[2] = 7'd35;
    tot_cnt++;
    if (bus.rd_data_vld !== 4'b0000)
      $display("FAIL wb_vld_pre got %b want 0000", bus.rd_data_vld);
    else pass_cnt++;
    step();
    idle();
    tot_cnt++;
    if (bus.rd_data[0] !== 64'h11 || bus.rd_data[1] !== 64'h22 || bus.rd_data[2] !== 64'h33)
      $display("FAIL wb_data got %h %h %h want 11 22 33", bus.rd_data[0], bus.rd_data[1], bus.rd_data[2]);
    else pass_cnt++;
    tot_cnt++;
    if (bus.rd_rdy[2:0] !== 3'b111 || bus.rd_data_vld !== 4'b0111)
      $display("FAIL wb_rdy rdy=%b vld=%b want 111/0111", bus.rd_rdy[2:0], bus.rd_data_vld);
    else pass_cnt++;
    tot_cnt++;
    if (bus.wb_conflict !== 1'b0)
      $display("FAIL wb_noconflict got %b want 0", bus.wb_conflict);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    bus.wb_vld = 3'b101;
    bus.wb_preg[0] = 7'd50; bus.wb_data[0] = 64'hAA;
    bus.wb_preg[2] = 7'd50; bus.wb_data[2] = 64'hBB;
    step();
    idle();
    tot_cnt++;
    if (bus.wb_conflict !== 1'b1 || bus.wb_conflict_preg !== 7'd50)
      $display("FAIL col_first got %b/%0d want 1/50", bus.wb_conflict, bus.wb_conflict_preg);
    else pass_cnt++;
    bus.rd_vld = 4'b0001;
    bus.rd_preg[0] = 7'd50;
    step();
    idle();
    tot_cnt++;
    if (bus.rd_data[0] !== 64'hAA || bus.rd_rdy[0] !== 1'b1)
      $display("FAIL col_data got %h/%b want aa/1", bus.rd_data[0], bus.rd_rdy[0]);
    else pass_cnt++;
    bus.wb_vld = 3'b011;
    bus.wb_preg[0] = 7'd60; bus.wb_data[0] = 64'h1;
    bus.wb_preg[1] = 7'd60; bus.wb_data[1] = 64'h2;
    step();
    idle();
    tot_cnt++;
    if (bus.wb_conflict !== 1'b1 || bus.wb_conflict_preg !== 7'd50)
      $display("FAIL col_keep got %b/%0d want 1/50", bus.wb_conflict, bus.wb_conflict_preg);
    else pass_cnt++;
    bus.conflict_clr = 1'b1;
    step();
    idle();
    tot_cnt++;
    if (bus.wb_conflict !== 1'b0 || bus.wb_conflict_preg !== 7'd0)
      $display("FAIL col_clr got %b/%0d want 0/0", bus.wb_conflict, bus.wb_conflict_preg);
    else pass_cnt++;
  endtask

  task automatic test_alloc_wb();
    bus.alloc_vld = 1'b1;
    bus.alloc_preg = 7'd40;
    bus.wb_vld = 3'b010;
    bus.wb_preg[1] = 7'd40; bus.wb_data[1] = 64'h7;
    step();
    idle();
    tot_cnt++;
    if (bus.wb_conflict !== 1'b1 || bus.wb_conflict_preg !== 7'd40)
      $display("FAIL alloc_conflict got %b/%0d want 1/40", bus.wb_conflict, bus.wb_conflict_preg);
    else pass_cnt++;
    bus.rd_vld = 4'b1000;
    bus.rd_preg[3] = 7'd40;
    step();
    idle();
    tot_cnt++;
    if (bus.rd_data[3] !== 64'h7 || bus.rd_rdy[3] !== 1'b0)
      $display("FAIL alloc_rd got %h/%b want 7/0", bus.rd_data[3], bus.rd_rdy[3]);
    else pass_cnt++;
    // Clear and a new collision in the same cycle: new index is captured.
    bus.conflict_clr = 1'b1;
    bus.wb_vld = 3'b110;
    bus.wb_preg[1] = 7'd70; bus.wb_data[1] = 64'h5;
    bus.wb_preg[2] = 7'd70; bus.wb_data[2] = 64'h6;
    step();
    idle();
    tot_cnt++;
    if (bus.wb_conflict !== 1'b1 || bus.wb_conflict_preg !== 7'd70)
      $display("FAIL clr_collide got %b/%0d want 1/70", bus.wb_conflict, bus.wb_conflict_preg);
    else pass_cnt++;
  endtask

  task automatic test_rd_wr_same();
    logic [63:0] exp_d;
`ifdef CT_IDU_PRF_BYPASS_EN
    exp_d = 64'h99;
`else
    exp_d = 64'h11;
`endif
    bus.wb_vld = 3'b001;
    bus.wb_preg[0] = 7'd33; bus.wb_data[0] = 64'h99;
    bus.rd_vld = 4'b0001;
    bus.rd_preg[0] = 7'd33;
    step();
    idle();
    tot_cnt++;
    if (bus.rd_data[0] !== exp_d || bus.rd_rdy[0] !== 1'b1)
      $display("FAIL rw_same got %h/%b want %h/1", bus.rd_data[0], bus.rd_rdy[0], exp_d);
    else pass_cnt++;
    step();
    tot_cnt++;
    if (bus.rd_data_vld[0] !== 1'b0 || bus.rd_data[0] !== exp_d)
      $display("FAIL rd_hold vld=%b data=%h want 0/%h", bus.rd_data_vld[0], bus.rd_data[0], exp_d);
    else pass_cnt++;
    bus.rd_vld = 4'b0001;
    bus.rd_preg[0] = 7'd33;
    step();
    idle();
    tot_cnt++;
    if (bus.rd_data[0] !== 64'h99 || bus.rd_data_vld[0] !== 1'b1)
      $display("FAIL rw_after got %h/%b want 99/1", bus.rd_data[0], bus.rd_data_vld[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_active();
    cpurst = 1'b1;
    bus.wb_vld = 3'b001;
    bus.wb_preg[0] = 7'd10; bus.wb_data[0] = 64'h55;
    bus.alloc_vld = 1'b1;
    bus.alloc_preg = 7'd5;
    bus.rd_vld = 4'b0001;
    bus.rd_preg[0] = 7'd33;
    step();
    cpurst = 1'b0;
    idle();
    tot_cnt++;
    if (bus.rd_data_vld !== 4'b0 || bus.rd_data !== '0 || bus.rd_rdy !== 4'b0)
      $display("FAIL rst_active_rd vld=%b rdy=%b want 0/0", bus.rd_data_vld, bus.rd_rdy);
    else pass_cnt++;
    tot_cnt++;
    if (bus.wb_conflict !== 1'b0 || bus.wb_conflict_preg !== 7'd0)
      $display("FAIL rst_active_col got %b/%0d want 0/0", bus.wb_conflict, bus.wb_conflict_preg);
    else pass_cnt++;
    bus.rd_vld = 4'b1111;
    bus.rd_preg[0] = 7'd10;
    bus.rd_preg[1] = 7'd33;
    bus.rd_preg[2] = 7'd5;
    bus.rd_preg[3] = 7'd40;
    step();
    idle();
    tot_cnt++;
    if (bus.rd_data !== '0)
      $display("FAIL rst_active_data got %h %h %h %h want 0", bus.rd_data[0], bus.rd_data[1],
               bus.rd_data[2], bus.rd_data[3]);
    else pass_cnt++;
    tot_cnt++;
    if (bus.rd_rdy !== 4'b0101)
      $display("FAIL rst_active_rdy got %b want 0101", bus.rd_rdy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_wb_ports();
    test_collision();
    test_alloc_wb();
    test_rd_wr_same();
    test_reset_active();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
